// File: rtl/rx_dfe_pkg.sv
`default_nettype none
// =============================================================================
// rx_dfe_pkg : FSM states, 4-PAM levels/symbols and width helpers for rx_dfe_*
// Revision   : 1.0
// =============================================================================
package rx_dfe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CALC    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  localparam logic [1:0] SYM_N3 = 2'b00;
  localparam logic [1:0] SYM_N1 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b10;
  localparam logic [1:0] SYM_P3 = 2'b11;

  localparam int SEP_DEFAULT = 56;

  // Symbol code s maps to level (2s-3)*SEP/2: -3S/2, -S/2, +S/2, +3S/2.
  function automatic int lvl_of(input logic [1:0] sym, input int sep);
    return ((2 * int'(sym)) - 3) * sep / 2;
  endfunction

  function automatic int est_w(input int sr, input int prl);
    return sr * prl;
  endfunction

  localparam int LVL_N3 = lvl_of(SYM_N3, SEP_DEFAULT);
  localparam int LVL_N1 = lvl_of(SYM_N1, SEP_DEFAULT);
  localparam int LVL_P1 = lvl_of(SYM_P1, SEP_DEFAULT);
  localparam int LVL_P3 = lvl_of(SYM_P3, SEP_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/rx_dfe_isi_mac.sv
`default_nettype none
// =============================================================================
// rx_dfe_isi_mac : combinational post-cursor ISI sum, sum(tap[i] * hist[i])
// Revision       : 1.0
// =============================================================================
module rx_dfe_isi_mac #(
  parameter int N_TAPS   = 4,
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 40
) (
  input  logic signed [SAMPLE_W-1:0] i_taps [N_TAPS],
  input  logic signed [SAMPLE_W-1:0] i_hist [N_TAPS],
  output logic signed [ACC_W-1:0]    o_acc
);

  localparam int c_prod_w = 2 * SAMPLE_W;

  logic signed [c_prod_w-1:0] w_prod [N_TAPS];

  for (genvar i = 0; i < N_TAPS; i++) begin : g_prod
    assign w_prod[i] = c_prod_w'(i_taps[i]) * c_prod_w'(i_hist[i]);
  end

  always_comb begin
    o_acc = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      o_acc = o_acc + ACC_W'(w_prod[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rx_dfe_sequencer.sv
`default_nettype none
// =============================================================================
// rx_dfe_sequencer : DFE loop sequencer around an external 4-PAM slicer.
// Revision 1.0 ; optional statistics ports under `RX_DFE_SEQ_STATS_EN
// =============================================================================
module rx_dfe_sequencer
  import rx_dfe_pkg::*;
#(
  parameter int PULSE_RESPONSE_LENGTH = 5,
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int SYMBOL_SEPERATION     = 56,
  parameter int TAP_FRAC              = 6
) (
  input  logic                                                  clk,
  input  logic                                                  rstn,
  input  logic signed [SIGNAL_RESOLUTION-1:0]                   s_sample,
  input  logic                                                  s_valid,
  output logic                                                  s_ready,
  input  logic                                                  cfg_we,
  input  logic [$clog2(PULSE_RESPONSE_LENGTH)-1:0]              cfg_addr,
  input  logic signed [SIGNAL_RESOLUTION-1:0]                   cfg_data,
  output logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0] est_out,
  output logic                                                  e_valid,
  input  logic signed [SIGNAL_RESOLUTION-1:0]                   fb_value,
  input  logic                                                  f_valid,
  output logic [1:0]                                            m_sym,
  output logic signed [SIGNAL_RESOLUTION-1:0]                   m_level,
  output logic                                                  m_valid,
  input  logic                                                  m_ready,
  output logic                                                  err
`ifdef RX_DFE_SEQ_STATS_EN
  ,
  output logic [31:0]                                           sym_count,
  output logic [15:0]                                           lvl_count [4]
`endif
);

  localparam int c_prl   = PULSE_RESPONSE_LENGTH;
  localparam int c_sr    = SIGNAL_RESOLUTION;
  localparam int c_nt    = c_prl - 1;
  localparam int c_est_w = est_w(c_sr, c_prl);

  localparam logic signed [c_sr-1:0] c_lvl_n3 = c_sr'(lvl_of(SYM_N3, SYMBOL_SEPERATION));
  localparam logic signed [c_sr-1:0] c_lvl_n1 = c_sr'(lvl_of(SYM_N1, SYMBOL_SEPERATION));
  localparam logic signed [c_sr-1:0] c_lvl_p1 = c_sr'(lvl_of(SYM_P1, SYMBOL_SEPERATION));
  localparam logic signed [c_sr-1:0] c_lvl_p3 = c_sr'(lvl_of(SYM_P3, SYMBOL_SEPERATION));

  state_t r_state;
  state_t w_state_nxt;

  logic signed [c_sr-1:0]    r_sample;
  logic signed [c_sr-1:0]    r_tap  [c_nt];  // r_tap[k] holds tap k+1
  logic signed [c_sr-1:0]    r_hist [c_nt];
  logic signed [c_est_w-1:0] w_acc;
  logic signed [c_est_w-1:0] w_est_nxt;
  logic signed [c_est_w-1:0] r_est;
  logic [1:0]                w_sym;
  logic                      w_lvl_ok;
  logic [1:0]                r_sym;
  logic signed [c_sr-1:0]    r_level;
  logic                      r_err;
  logic                      w_s_ready;
  logic                      w_e_valid;
  logic                      w_m_valid;

  rx_dfe_isi_mac #(
    .N_TAPS   (c_nt),
    .SAMPLE_W (c_sr),
    .ACC_W    (c_est_w)
  ) u_isi_mac (
    .i_taps (r_tap),
    .i_hist (r_hist),
    .o_acc  (w_acc)
  );

  assign w_est_nxt = c_est_w'(r_sample) - (w_acc >>> TAP_FRAC);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_e_valid   = 1'b0;
    w_m_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_s_ready = 1'b1;
        if (s_valid) w_state_nxt = ST_CALC;
      end
      ST_CALC:    w_state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        w_e_valid   = 1'b1;
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: w_state_nxt = ST_OUT;
      ST_OUT: begin
        w_m_valid = 1'b1;
        if (m_ready) w_state_nxt = ST_IDLE;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sym    = SYM_N3;
    w_lvl_ok = 1'b1;
    if (fb_value == c_lvl_n3)      w_sym = SYM_N3;
    else if (fb_value == c_lvl_n1) w_sym = SYM_N1;
    else if (fb_value == c_lvl_p1) w_sym = SYM_P1;
    else if (fb_value == c_lvl_p3) w_sym = SYM_P3;
    else                           w_lvl_ok = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sample <= '0;
      r_est    <= '0;
      r_sym    <= '0;
      r_level  <= '0;
      r_err    <= 1'b0;
      for (int k = 0; k < c_nt; k++) begin
        r_tap[k]  <= '0;
        r_hist[k] <= '0;
      end
    end else begin
      // Tap writes land at the same edge that closes CALC, so they affect the next CALC.
      for (int k = 0; k < c_nt; k++) begin
        if (cfg_we && (int'(cfg_addr) == k + 1)) r_tap[k] <= cfg_data;
      end
      case (r_state)
        ST_IDLE: if (s_valid) r_sample <= s_sample;
        ST_CALC: r_est <= w_est_nxt;
        ST_CAPTURE: begin
          r_hist[0] <= fb_value;
          for (int k = 1; k < c_nt; k++) r_hist[k] <= r_hist[k-1];
          r_sym   <= w_sym;
          r_level <= fb_value;
          if (!f_valid || !w_lvl_ok) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_ready = w_s_ready;
  assign e_valid = w_e_valid;
  assign m_valid = w_m_valid;
  assign est_out = r_est;
  assign m_sym   = r_sym;
  assign m_level = r_level;
  assign err     = r_err;

`ifdef RX_DFE_SEQ_STATS_EN
  logic [31:0] r_sym_count;
  logic [15:0] r_lvl_count [4];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sym_count <= '0;
      for (int k = 0; k < 4; k++) r_lvl_count[k] <= '0;
    end else if (w_m_valid && m_ready) begin
      r_sym_count <= r_sym_count + 32'd1;
      for (int k = 0; k < 4; k++) begin
        if ((int'(r_sym) == k) && (r_lvl_count[k] != 16'hFFFF)) begin
          r_lvl_count[k] <= r_lvl_count[k] + 16'd1;
        end
      end
    end
  end

  assign sym_count = r_sym_count;
  assign lvl_count = r_lvl_count;
`endif

endmodule
`default_nettype wire
